// File: rtl/qrs_peak_detector.sv
// -----------------------------------------------------------------------------
// qrs_peak_detector
//   Finds R-peaks in a per-cycle ECG sample stream and reports one pulse per
//   beat. The detector works in four phases:
//     LEARN   - take the running maximum of the first LEARN_LEN valid samples.
//               This seeds the signal-peak estimate (spk) and the threshold.
//     SEARCH  - wait for a sample strictly above the threshold.
//     TRACK   - follow the QRS complex and keep the largest sample as the
//               candidate. The candidate is emitted when the signal drops back
//               to or below the threshold, or after MAX_QRS samples.
//     REFRACT - skip REFRACT_LEN valid samples so one beat yields one pulse.
//   When a candidate is emitted, spk moves 1/8 of the way toward the new peak
//   amplitude, and the threshold becomes spk/2.
//
// Ports
//   clk           in   clock
//   nrst          in   synchronous active-low reset
//   sample_in     in   [DATA_WIDTH-1:0] unsigned ECG sample
//   sample_valid  in   sample_in / sample_idx qualify this cycle
//   sample_idx    in   [CTR_WIDTH-1:0] index of sample_in
//   peak_valid    out  one-cycle pulse; peak_* and rr_* updated
//   peak_index    out  [CTR_WIDTH-1:0] index of detected R-peak
//   peak_amp      out  [DATA_WIDTH-1:0] amplitude of detected R-peak
//   rr_interval   out  [CTR_WIDTH-1:0] peak_index - previous peak_index (modular)
//   rr_valid      out  rr_interval meaningful (0 for first peak after reset)
//   threshold     out  [DATA_WIDTH-1:0] current detection threshold
//   learning      out  high while in LEARN
// -----------------------------------------------------------------------------
module qrs_peak_detector #(
  parameter int DATA_WIDTH  = 11,
  parameter int CTR_WIDTH   = 24,
  parameter int LEARN_LEN   = 720,
  parameter int REFRACT_LEN = 72,
  parameter int MAX_QRS     = 54
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [CTR_WIDTH-1:0]  sample_idx,
  output logic                  peak_valid,
  output logic [CTR_WIDTH-1:0]  peak_index,
  output logic [DATA_WIDTH-1:0] peak_amp,
  output logic [CTR_WIDTH-1:0]  rr_interval,
  output logic                  rr_valid,
  output logic [DATA_WIDTH-1:0] threshold,
  output logic                  learning
);

  localparam int LCW = $clog2(LEARN_LEN + 1);
  localparam int RCW = $clog2(REFRACT_LEN + 1);
  localparam int QCW = $clog2(MAX_QRS + 1);

  // The "last" constants are reached on the final counted sample, so the
  // phase ends on the same edge that consumes that sample.
  localparam logic [LCW-1:0] LEARN_LAST = LCW'(LEARN_LEN - 1);
  localparam logic [RCW-1:0] REF_LAST   = RCW'(REFRACT_LEN - 1);
  localparam logic [QCW-1:0] QRS_LAST   = QCW'(MAX_QRS - 1);

  typedef enum logic [1:0] {
    ST_LEARN   = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_TRACK   = 2'd2,
    ST_REFRACT = 2'd3
  } state_t;

  // spk <- spk - spk/8 + amp/8. The result never exceeds max(spk, amp), so
  // the wider intermediate can be truncated back to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] spk_update(
    input logic [DATA_WIDTH-1:0] spk,
    input logic [DATA_WIDTH-1:0] amp
  );
    logic [DATA_WIDTH:0] acc;
    acc = {1'b0, spk} - {4'b0000, spk[DATA_WIDTH-1:3]} + {4'b0000, amp[DATA_WIDTH-1:3]};
    return acc[DATA_WIDTH-1:0];
  endfunction

  state_t                state_r, state_s;
  logic [LCW-1:0]        learn_cnt_r, learn_cnt_s;
  logic [RCW-1:0]        ref_cnt_r, ref_cnt_s;
  logic [QCW-1:0]        qrs_cnt_r, qrs_cnt_s;
  logic [DATA_WIDTH-1:0] max_r, max_s;
  logic [DATA_WIDTH-1:0] spk_r, spk_s, new_spk_s;
  logic [DATA_WIDTH-1:0] thr_r, thr_s;
  logic [DATA_WIDTH-1:0] cand_amp_r, cand_amp_s;
  logic [CTR_WIDTH-1:0]  cand_idx_r, cand_idx_s;
  logic [CTR_WIDTH-1:0]  last_idx_r, last_idx_s;
  logic                  have_last_r, have_last_s;
  logic                  emit_s;
  logic [DATA_WIDTH-1:0] emit_amp_s;
  logic [CTR_WIDTH-1:0]  emit_idx_s;
  logic [CTR_WIDTH-1:0]  rr_s;

  logic                  peak_valid_r;
  logic [CTR_WIDTH-1:0]  peak_index_r;
  logic [DATA_WIDTH-1:0] peak_amp_r;
  logic [CTR_WIDTH-1:0]  rr_interval_r;
  logic                  rr_valid_r;
  logic                  learning_r;

  // Next-state and datapath update; everything holds unless sample_valid.
  always_comb begin
    state_s     = state_r;
    learn_cnt_s = learn_cnt_r;
    ref_cnt_s   = ref_cnt_r;
    qrs_cnt_s   = qrs_cnt_r;
    max_s       = max_r;
    spk_s       = spk_r;
    new_spk_s   = spk_r;
    thr_s       = thr_r;
    cand_amp_s  = cand_amp_r;
    cand_idx_s  = cand_idx_r;
    last_idx_s  = last_idx_r;
    have_last_s = have_last_r;
    emit_s      = 1'b0;
    emit_amp_s  = cand_amp_r;
    emit_idx_s  = cand_idx_r;
    rr_s        = cand_idx_r - last_idx_r;

    if (sample_valid) begin
      case (state_r)
        ST_LEARN: begin
          if (sample_in > max_r) begin
            max_s = sample_in;
          end else begin
            max_s = max_r;
          end
          // The closing learn sample seeds spk/threshold only; it is not
          // itself tested against the threshold.
          if (learn_cnt_r == LEARN_LAST) begin
            spk_s       = max_s;
            thr_s       = {1'b0, max_s[DATA_WIDTH-1:1]};
            learn_cnt_s = {LCW{1'b0}};
            state_s     = ST_SEARCH;
          end else begin
            learn_cnt_s = learn_cnt_r + LCW'(1);
          end
        end
        ST_SEARCH: begin
          if (sample_in > thr_r) begin
            cand_amp_s = sample_in;
            cand_idx_s = sample_idx;
            qrs_cnt_s  = QCW'(1);
            state_s    = ST_TRACK;
          end else begin
            state_s = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          if (sample_in <= thr_r) begin
            // The candidate is already above threshold, so this sample
            // cannot replace it.
            emit_s = 1'b1;
          end else begin
            // A strict compare means a plateau keeps its earliest index.
            if (sample_in > cand_amp_r) begin
              cand_amp_s = sample_in;
              cand_idx_s = sample_idx;
            end else begin
              cand_amp_s = cand_amp_r;
            end
            if (qrs_cnt_r == QRS_LAST) begin
              emit_s = 1'b1;
            end else begin
              qrs_cnt_s = qrs_cnt_r + QCW'(1);
            end
          end
          emit_amp_s = cand_amp_s;
          emit_idx_s = cand_idx_s;
        end
        ST_REFRACT: begin
          if (ref_cnt_r == REF_LAST) begin
            ref_cnt_s = {RCW{1'b0}};
            state_s   = ST_SEARCH;
          end else begin
            ref_cnt_s = ref_cnt_r + RCW'(1);
          end
        end
        default: begin
          state_s = ST_LEARN;
        end
      endcase

      rr_s = emit_idx_s - last_idx_r;
      if (emit_s) begin
        new_spk_s   = spk_update(spk_r, emit_amp_s);
        spk_s       = new_spk_s;
        thr_s       = {1'b0, new_spk_s[DATA_WIDTH-1:1]};
        last_idx_s  = emit_idx_s;
        have_last_s = 1'b1;
        ref_cnt_s   = {RCW{1'b0}};
        state_s     = ST_REFRACT;
      end else begin
        new_spk_s = spk_r;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r       <= ST_LEARN;
      learn_cnt_r   <= {LCW{1'b0}};
      ref_cnt_r     <= {RCW{1'b0}};
      qrs_cnt_r     <= {QCW{1'b0}};
      max_r         <= {DATA_WIDTH{1'b0}};
      spk_r         <= {DATA_WIDTH{1'b0}};
      thr_r         <= {DATA_WIDTH{1'b0}};
      cand_amp_r    <= {DATA_WIDTH{1'b0}};
      cand_idx_r    <= {CTR_WIDTH{1'b0}};
      last_idx_r    <= {CTR_WIDTH{1'b0}};
      have_last_r   <= 1'b0;
      peak_valid_r  <= 1'b0;
      peak_index_r  <= {CTR_WIDTH{1'b0}};
      peak_amp_r    <= {DATA_WIDTH{1'b0}};
      rr_interval_r <= {CTR_WIDTH{1'b0}};
      rr_valid_r    <= 1'b0;
      learning_r    <= 1'b1;
    end else begin
      state_r      <= state_s;
      learn_cnt_r  <= learn_cnt_s;
      ref_cnt_r    <= ref_cnt_s;
      qrs_cnt_r    <= qrs_cnt_s;
      max_r        <= max_s;
      spk_r        <= spk_s;
      thr_r        <= thr_s;
      cand_amp_r   <= cand_amp_s;
      cand_idx_r   <= cand_idx_s;
      last_idx_r   <= last_idx_s;
      have_last_r  <= have_last_s;
      peak_valid_r <= emit_s;
      learning_r   <= (state_s == ST_LEARN);
      if (emit_s) begin
        peak_index_r  <= emit_idx_s;
        peak_amp_r    <= emit_amp_s;
        rr_interval_r <= rr_s;
        rr_valid_r    <= have_last_r;
      end else begin
        peak_index_r  <= peak_index_r;
        peak_amp_r    <= peak_amp_r;
        rr_interval_r <= rr_interval_r;
        rr_valid_r    <= rr_valid_r;
      end
    end
  end

  assign peak_valid  = peak_valid_r;
  assign peak_index  = peak_index_r;
  assign peak_amp    = peak_amp_r;
  assign rr_interval = rr_interval_r;
  assign rr_valid    = rr_valid_r;
  assign threshold   = thr_r;
  assign learning    = learning_r;

endmodule
